host_frame_link: RTL

- Byte-to-word bridge between the host UART byte interface and the sandbox process.
- RX path: collects a 5-byte host frame (control byte, then 32-bit data word MSB first) and presents it on dataReceived/control/inputData. It holds the frame until the process raises clearDR.
- TX path: on transmitData, serialises status plus outputData back to the UART as a 5-byte frame.
- Sits directly upstream of the sandbox process, and downstream of it for the reply.

---
 rtl/host_link_pkg.sv | 24 ++
 rtl/host_frame_tx.sv | 74 +++++++
 rtl/host_frame_link.sv | 123 ++++++++++++
 3 files changed

// File: rtl/host_link_pkg.sv
// Shared frame geometry and FSM encodings for the host UART frame link.
package host_link_pkg;

  localparam int FRAME_BYTES = 5;
  localparam int FRAME_W     = FRAME_BYTES * 8;
  localparam int BYTE_IDX_W  = $clog2(FRAME_BYTES);

  typedef logic [BYTE_IDX_W-1:0] byte_idx_t;

  // Index of the final byte of a frame (control byte is index 0).
  localparam byte_idx_t LAST_IDX = byte_idx_t'(FRAME_BYTES - 1);

  typedef enum logic [1:0] {
    RX_IDLE,
    RX_COLLECT,
    RX_HOLD
  } rx_state_e;

  typedef enum logic {
    TX_IDLE,
    TX_SEND
  } tx_state_e;

endpackage

// File: rtl/host_frame_tx.sv
// Reply serialiser: captures status/payload on an armed request and offers
// the 5-byte frame MSB first on a registered valid/ready byte interface.
module host_frame_tx
  import host_link_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        request,
  input  logic [7:0]  status,
  input  logic [31:0] payload,
  input  logic        tx_ready,
  output logic [7:0]  tx_byte,
  output logic        tx_valid
);

  tx_state_e          state, state_next;
  logic [FRAME_W-1:0] shreg;
  byte_idx_t          cnt;
  logic               armed;
  logic               start;
  logic               accept;

  // Next state: launch on an armed request, return once the last byte is taken.
  always_comb begin
    state_next = state;
    start      = 1'b0;
    accept     = 1'b0;
    unique case (state)
      TX_IDLE: begin
        if (request && armed) begin
          start      = 1'b1;
          state_next = TX_SEND;
        end
      end
      TX_SEND: begin
        accept = tx_ready;
        if (tx_ready && cnt == LAST_IDX) state_next = TX_IDLE;
      end
      default: state_next = TX_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= TX_IDLE;
    else     state <= state_next;
  end

  // Shift register, byte counter and request arming (re-arms only while idle
  // with the request low, so a held request never launches a second frame).
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shreg <= '0;
      cnt   <= '0;
      armed <= 1'b0;
    end else begin
      if (state == TX_IDLE && !request) armed <= 1'b1;
      else if (start)                   armed <= 1'b0;

      if (start) begin
        shreg <= {status, payload};
        cnt   <= '0;
      end else if (accept) begin
        shreg <= shreg << 8;
        cnt   <= cnt + 1'b1;
      end
    end
  end

  // Both outputs come straight from registers.
  assign tx_byte  = shreg[FRAME_W-1 -: 8];
  assign tx_valid = (state == TX_SEND);

endmodule

// File: rtl/host_frame_link.sv
// Host UART byte <-> 5-byte frame bridge. RX assembles control + 32-bit word
// and holds it until the process clears it; TX is delegated to host_frame_tx.
module host_frame_link
  import host_link_pkg::*;
#(
  parameter int unsigned RX_TIMEOUT = 1000000  // idle cycles tolerated mid-frame, >= 1
) (
  input  logic        masterClock,
  input  logic        reset,
  input  logic        rxValid,
  input  logic [7:0]  rxByte,
  output logic [7:0]  txByte,
  output logic        txValid,
  input  logic        txReady,
  output logic        dataReceived,
  output logic [7:0]  control,
  output logic [31:0] inputData,
  input  logic        clearDR,
  input  logic        transmitData,
  input  logic [7:0]  status,
  input  logic [31:0] outputData,
  output logic        rxOverrun,
  output logic        rxTimeout
);

  localparam int                IDLE_W     = $clog2(RX_TIMEOUT + 1);
  localparam logic [IDLE_W-1:0] IDLE_LIMIT = IDLE_W'(RX_TIMEOUT);

  rx_state_e         rx_state, rx_next;
  byte_idx_t         byte_cnt;
  logic [IDLE_W-1:0] idle_cnt;
  logic              clr_armed;
  logic              timeout_hit;

  // RX next state; an expired idle counter takes priority over a same-cycle byte.
  always_comb begin
    rx_next     = rx_state;
    timeout_hit = 1'b0;
    unique case (rx_state)
      RX_IDLE: begin
        if (rxValid) rx_next = RX_COLLECT;
      end
      RX_COLLECT: begin
        if (idle_cnt == IDLE_LIMIT) begin
          timeout_hit = 1'b1;
          rx_next     = RX_IDLE;
        end else if (rxValid && byte_cnt == LAST_IDX) begin
          rx_next = RX_HOLD;
        end
      end
      RX_HOLD: begin
        if (clr_armed && clearDR) rx_next = RX_IDLE;
      end
      default: rx_next = RX_IDLE;
    endcase
  end

  // RX state register.
  always_ff @(posedge masterClock or posedge reset) begin
    if (reset) rx_state <= RX_IDLE;
    else       rx_state <= rx_next;
  end

  // RX datapath: byte capture, counters, clear arming and event pulses.
  always_ff @(posedge masterClock or posedge reset) begin
    if (reset) begin
      control   <= '0;
      inputData <= '0;
      byte_cnt  <= '0;
      idle_cnt  <= '0;
      clr_armed <= 1'b0;
      rxOverrun <= 1'b0;
      rxTimeout <= 1'b0;
    end else begin
      rxOverrun <= (rx_state == RX_HOLD) && rxValid;
      rxTimeout <= timeout_hit;
      unique case (rx_state)
        RX_IDLE: begin
          if (rxValid) begin
            control  <= rxByte;
            byte_cnt <= byte_idx_t'(1);
            idle_cnt <= '0;
          end
        end
        RX_COLLECT: begin
          if (timeout_hit) begin
            byte_cnt <= '0;
          end else if (rxValid) begin
            inputData <= {inputData[23:0], rxByte};
            idle_cnt  <= '0;
            if (byte_cnt == LAST_IDX) begin
              // A clear still high from the last handshake must not release this frame.
              byte_cnt  <= '0;
              clr_armed <= 1'b0;
            end else begin
              byte_cnt <= byte_cnt + 1'b1;
            end
          end else begin
            idle_cnt <= idle_cnt + 1'b1;
          end
        end
        RX_HOLD: begin
          if (!clearDR) clr_armed <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign dataReceived = (rx_state == RX_HOLD);

  host_frame_tx u_tx (
    .clk      (masterClock),
    .rst      (reset),
    .request  (transmitData),
    .status   (status),
    .payload  (outputData),
    .tx_ready (txReady),
    .tx_byte  (txByte),
    .tx_valid (txValid)
  );

endmodule
